// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative unsigned multiply / divide unit for the multi-cycle
// MUL/DIV instructions. Operands come straight from the register file read
// ports. The result and write strobe are shaped to drive the register file
// write port directly.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           request, sampled only while idle
//   op              0 = multiply, 1 = divide (captured with start)
//   operand_a       multiplicand / dividend
//   operand_b       multiplier / divisor
//   dest            destination register index (captured with start)
//   busy            high whenever an operation is in flight
//   done            one-cycle completion pulse (register_write)
//   write_address   captured dest, held until the next completion
//   result_lo       product[W-1:0] or quotient (write_data)
//   result_hi       product[2W-1:W] or remainder
//   div_by_zero     divide with zero divisor; held until the next accepted start
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; results from the last operation held
// S_RUN  | one shift-add / restoring-divide iteration per cycle
// S_DONE | done asserted for exactly one cycle, results valid

module mul_div_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [2:0]       dest,
   output logic             busy,
   output logic             done,
   output logic [2:0]       write_address,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic               op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2:0]         dest_q;
   logic [CW-1:0]      cnt_q;
   // Multiply: full product accumulator.
   // Divide: {partial remainder, dividend shifting out MSB-first / quotient shifting in}.
   logic [2*WIDTH-1:0] work_q;

   logic               start_dbz;
   logic [2*WIDTH-1:0] mul_addend;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shifted;
   logic [WIDTH+1:0]   div_diff;
   logic               div_ge;
   logic [WIDTH-1:0]   div_rem_next;
   logic [2*WIDTH-1:0] div_next;
   logic [2*WIDTH-1:0] work_next;

   assign start_dbz = op && (operand_b == '0);

   // ---------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = start_dbz ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (cnt_q == CNT_LAST) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);

   // ---------------------------------------------------------------
   // Iteration datapath
   // ---------------------------------------------------------------
   always_comb begin
      mul_addend = {{WIDTH{1'b0}}, a_q} << cnt_q;
      mul_next   = work_q + (b_q[cnt_q[CW-2:0]] ? mul_addend : '0);

      // Bring down the next dividend bit and try a 17-bit subtract; the
      // extra top bit of div_diff is the borrow.
      div_shifted  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
      div_diff     = {1'b0, div_shifted} - {2'b00, b_q};
      div_ge       = ~div_diff[WIDTH+1];
      div_rem_next = div_ge ? div_diff[WIDTH-1:0] : div_shifted[WIDTH-1:0];
      div_next     = {div_rem_next, work_q[WIDTH-2:0], div_ge};

      work_next = op_q ? div_next : mul_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q          <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         dest_q        <= '0;
         cnt_q         <= '0;
         work_q        <= '0;
         write_address <= '0;
         result_lo     <= '0;
         result_hi     <= '0;
         div_by_zero   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q        <= op;
                  a_q         <= operand_a;
                  b_q         <= operand_b;
                  dest_q      <= dest;
                  cnt_q       <= '0;
                  work_q      <= op ? {{WIDTH{1'b0}}, operand_a} : '0;
                  div_by_zero <= 1'b0;
                  // Zero divisor skips RUN, so results load on this edge.
                  if (start_dbz) begin
                     result_lo     <= '1;
                     result_hi     <= operand_a;
                     write_address <= dest;
                     div_by_zero   <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               work_q <= work_next;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  result_lo     <= work_next[WIDTH-1:0];
                  result_hi     <= work_next[2*WIDTH-1:WIDTH];
                  write_address <= dest_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op;
   logic [15:0] operand_a;
   logic [15:0] operand_b;
   logic [2:0]  dest;
   logic        busy;
   logic        done;
   logic [2:0]  write_address;
   logic [15:0] result_lo;
   logic [15:0] result_hi;
   logic        div_by_zero;

   int pass_count  = 0;
   int check_count = 0;
   int done_seen   = 0;

   mul_div_unit #(.WIDTH(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .op            (op),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .dest          (dest),
      .busy          (busy),
      .done          (done),
      .write_address (write_address),
      .result_lo     (result_lo),
      .result_hi     (result_hi),
      .div_by_zero   (div_by_zero)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_seen++;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives start for one edge (edge N); returns in cycle N+1.
   task automatic issue(input logic o, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] d);
      start = 1'b1; op = o; operand_a = a; operand_b = b; dest = d;
      tick(1);
      start = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick(3);
      check_count++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_count++;
      check_count++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_count++;
      check_count++; if (write_address !== 3'd0) $display("FAIL reset_wa got %0d want 0", write_address); else pass_count++;
      check_count++; if (result_lo !== 16'h0) $display("FAIL reset_lo got %h want 0000", result_lo); else pass_count++;
      check_count++; if (result_hi !== 16'h0) $display("FAIL reset_hi got %h want 0000", result_hi); else pass_count++;
      check_count++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz got %b want 0", div_by_zero); else pass_count++;
      rst = 1'b0;
      tick(1);
   endtask

   task automatic run_vectors(input string tag, input logic o, input logic [15:0] va [4],
                              input logic [15:0] vb [4], input logic [15:0] vlo [4],
                              input logic [15:0] vhi [4]);
      for (int i = 0; i < 4; i++) begin
         issue(o, va[i], vb[i], 3'(i + 1));
         check_count++; if (busy !== 1'b1) $display("FAIL %s%0d_busy_n1 got %b want 1", tag, i, busy); else pass_count++;
         tick(15);
         check_count++; if (done !== 1'b0) $display("FAIL %s%0d_early_done got %b want 0", tag, i, done); else pass_count++;
         tick(1);
         check_count++; if (done !== 1'b1) $display("FAIL %s%0d_done got %b want 1", tag, i, done); else pass_count++;
         check_count++; if (result_lo !== vlo[i]) $display("FAIL %s%0d_lo got %h want %h", tag, i, result_lo, vlo[i]); else pass_count++;
         check_count++; if (result_hi !== vhi[i]) $display("FAIL %s%0d_hi got %h want %h", tag, i, result_hi, vhi[i]); else pass_count++;
         check_count++; if (write_address !== 3'(i + 1)) $display("FAIL %s%0d_wa got %0d want %0d", tag, i, write_address, i + 1); else pass_count++;
         check_count++; if (div_by_zero !== 1'b0) $display("FAIL %s%0d_dbz got %b want 0", tag, i, div_by_zero); else pass_count++;
         tick(1);
         check_count++; if (done !== 1'b0) $display("FAIL %s%0d_done_width got %b want 0", tag, i, done); else pass_count++;
         check_count++; if (busy !== 1'b0) $display("FAIL %s%0d_busy_n18 got %b want 0", tag, i, busy); else pass_count++;
         check_count++; if (result_lo !== vlo[i]) $display("FAIL %s%0d_lo_hold got %h want %h", tag, i, result_lo, vlo[i]); else pass_count++;
      end
   endtask

   task automatic test_mul;
      logic [15:0] va [4], vb [4], vlo [4], vhi [4];
      va  = '{16'h1234, 16'hFFFF, 16'h4444, 16'h00FF};
      vb  = '{16'h0010, 16'hFFFF, 16'h0000, 16'h0101};
      vlo = '{16'h2340, 16'h0001, 16'h0000, 16'hFFFF};
      vhi = '{16'h0001, 16'hFFFE, 16'h0000, 16'h0000};
      run_vectors("mul", 1'b0, va, vb, vlo, vhi);
   endtask

   task automatic test_div;
      logic [15:0] va [4], vb [4], vlo [4], vhi [4];
      va  = '{16'hFFFD, 16'h0003, 16'h8000, 16'h0064};
      vb  = '{16'h0007, 16'h4000, 16'h0001, 16'h000A};
      vlo = '{16'h2491, 16'h0000, 16'h8000, 16'h000A};
      vhi = '{16'h0006, 16'h0003, 16'h0000, 16'h0000};
      run_vectors("div", 1'b1, va, vb, vlo, vhi);
   endtask

   task automatic test_div_zero;
      issue(1'b1, 16'h4444, 16'h0000, 3'd6);
      check_count++; if (done !== 1'b1) $display("FAIL dz_done got %b want 1", done); else pass_count++;
      check_count++; if (result_lo !== 16'hFFFF) $display("FAIL dz_lo got %h want ffff", result_lo); else pass_count++;
      check_count++; if (result_hi !== 16'h4444) $display("FAIL dz_hi got %h want 4444", result_hi); else pass_count++;
      check_count++; if (div_by_zero !== 1'b1) $display("FAIL dz_flag got %b want 1", div_by_zero); else pass_count++;
      check_count++; if (write_address !== 3'd6) $display("FAIL dz_wa got %0d want 6", write_address); else pass_count++;
      tick(1);
      check_count++; if (busy !== 1'b0) $display("FAIL dz_busy_n2 got %b want 0", busy); else pass_count++;
      check_count++; if (div_by_zero !== 1'b1) $display("FAIL dz_flag_hold got %b want 1", div_by_zero); else pass_count++;
      issue(1'b1, 16'h0064, 16'h0007, 3'd2);
      check_count++; if (div_by_zero !== 1'b0) $display("FAIL dz_clear got %b want 0", div_by_zero); else pass_count++;
      tick(16);
      check_count++; if (done !== 1'b1) $display("FAIL dz_next_done got %b want 1", done); else pass_count++;
      check_count++; if (result_lo !== 16'h000E) $display("FAIL dz_next_lo got %h want 000e", result_lo); else pass_count++;
      check_count++; if (result_hi !== 16'h0002) $display("FAIL dz_next_hi got %h want 0002", result_hi); else pass_count++;
      tick(1);
   endtask

   task automatic test_start_while_busy;
      int base;
      base = done_seen;
      issue(1'b0, 16'h1234, 16'h0010, 3'd5);
      tick(3);
      start = 1'b1; op = 1'b1; operand_a = 16'h00FF; operand_b = 16'h0003; dest = 3'd2;
      tick(1);
      start = 1'b0; operand_a = 16'hFFFF; operand_b = 16'hFFFF;
      tick(12);
      check_count++; if (done !== 1'b1) $display("FAIL swb_done got %b want 1", done); else pass_count++;
      check_count++; if (result_lo !== 16'h2340) $display("FAIL swb_lo got %h want 2340", result_lo); else pass_count++;
      check_count++; if (result_hi !== 16'h0001) $display("FAIL swb_hi got %h want 0001", result_hi); else pass_count++;
      check_count++; if (write_address !== 3'd5) $display("FAIL swb_wa got %0d want 5", write_address); else pass_count++;
      tick(20);
      check_count++; if (done_seen - base !== 1) $display("FAIL swb_done_count got %0d want 1", done_seen - base); else pass_count++;
      check_count++; if (busy !== 1'b0) $display("FAIL swb_busy got %b want 0", busy); else pass_count++;
   endtask

   task automatic test_reset_mid_run;
      int base;
      issue(1'b0, 16'hFFFF, 16'hFFFF, 3'd7);
      tick(7);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      base = done_seen;
      check_count++; if (busy !== 1'b0) $display("FAIL rmr_busy got %b want 0", busy); else pass_count++;
      check_count++; if (done !== 1'b0) $display("FAIL rmr_done got %b want 0", done); else pass_count++;
      check_count++; if (result_lo !== 16'h0) $display("FAIL rmr_lo got %h want 0000", result_lo); else pass_count++;
      check_count++; if (result_hi !== 16'h0) $display("FAIL rmr_hi got %h want 0000", result_hi); else pass_count++;
      check_count++; if (write_address !== 3'd0) $display("FAIL rmr_wa got %0d want 0", write_address); else pass_count++;
      tick(20);
      check_count++; if (done_seen !== base) $display("FAIL rmr_no_done got %0d want %0d", done_seen, base); else pass_count++;
      issue(1'b0, 16'h0003, 16'h0005, 3'd1);
      tick(16);
      check_count++; if (done !== 1'b1) $display("FAIL rmr_fresh_done got %b want 1", done); else pass_count++;
      check_count++; if (result_lo !== 16'h000F) $display("FAIL rmr_fresh_lo got %h want 000f", result_lo); else pass_count++;
      check_count++; if (write_address !== 3'd1) $display("FAIL rmr_fresh_wa got %0d want 1", write_address); else pass_count++;
      tick(1);
   endtask

   task automatic test_reset_priority;
      int base;
      base = done_seen;
      rst = 1'b1;
      start = 1'b1; op = 1'b0; operand_a = 16'h0002; operand_b = 16'h0002; dest = 3'd3;
      tick(1);
      rst = 1'b0; start = 1'b0;
      check_count++; if (busy !== 1'b0) $display("FAIL rprio_busy got %b want 0", busy); else pass_count++;
      check_count++; if (result_lo !== 16'h0) $display("FAIL rprio_lo got %h want 0000", result_lo); else pass_count++;
      tick(20);
      check_count++; if (done_seen !== base) $display("FAIL rprio_no_done got %0d want %0d", done_seen, base); else pass_count++;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 1'b0;
      operand_a = '0; operand_b = '0; dest = '0;
      test_reset();
      test_mul();
      test_div();
      test_div_zero();
      test_start_while_busy();
      test_reset_mid_run();
      test_reset_priority();
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
